regfile_dump: RTL and testbench

Parametrised successor to the single-cycle datapath register file: XLEN×NREGS storage with two combinational read ports and one synchronous write port, plus a built-in dump engine. The dump engine streams every register out over a valid/ready channel in index order. It replaces the bench-side read-port muxing used for end-of-test register checking. It sits between the decoder/ALU writeback path and either the result-checking bench or a debug port.

---
 rtl/regfile_dump_pkg.sv | 15 +
 rtl/regfile_core.sv | 52 +++++
 rtl/regfile_dump.sv | 104 ++++++++++
 tb/tb_regfile_dump.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_dump_pkg.sv
// Shared types and default sizes for the register file and its dump engine.
package regfile_dump_pkg;

    // Default datapath sizes, also used by the decoder and ALU.
    localparam int DEF_XLEN  = 32;
    localparam int DEF_NREGS = 32;

    // Dump engine states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } dump_state_t;

endpackage

// File: rtl/regfile_core.sv
// Register storage with two combinational read ports, one dump read port,
// and a gated synchronous write port. Register 0 can be hardwired to zero.
module regfile_core
    import regfile_dump_pkg::*;
#(
    parameter int XLEN     = DEF_XLEN,
    parameter int NREGS    = DEF_NREGS,
    parameter int ZERO_REG = 1,
    parameter int AW       = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [AW-1:0]   rs1,
    input  logic [AW-1:0]   rs2,
    input  logic [AW-1:0]   rs3,
    output logic [XLEN-1:0] rv1,
    output logic [XLEN-1:0] rv2,
    output logic [XLEN-1:0] rv3,
    input  logic [AW-1:0]   rd,
    input  logic            we,
    input  logic [XLEN-1:0] wdata,
    input  logic            wr_inhibit
);

    logic [XLEN-1:0] regs [NREGS];
    logic            wr_en;
    logic            rd_is_zero;

    // Writes to a hardwired x0 are silently ignored; writes are also blocked
    // while the dump engine owns the array so its beats stay stable.
    always_comb begin
        rd_is_zero = (ZERO_REG != 0) && (rd == '0);
        wr_en      = we && !wr_inhibit && !rd_is_zero;
    end

    // Storage update; reset clears every register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else if (wr_en) begin
            regs[rd] <= wdata;
        end
    end

    // Read muxes; x0 is forced to zero so its storage value never matters.
    always_comb begin
        rv1 = ((ZERO_REG != 0) && (rs1 == '0)) ? '0 : regs[rs1];
        rv2 = ((ZERO_REG != 0) && (rs2 == '0)) ? '0 : regs[rs2];
        rv3 = ((ZERO_REG != 0) && (rs3 == '0)) ? '0 : regs[rs3];
    end

endmodule

// File: rtl/regfile_dump.sv
// Register file with a streaming dump engine: on request, every register is
// sent out over a valid/ready channel in index order, then a done pulse.
module regfile_dump
    import regfile_dump_pkg::*;
#(
    parameter  int XLEN     = DEF_XLEN,
    parameter  int NREGS    = DEF_NREGS,
    parameter  int ZERO_REG = 1,
    localparam int AW       = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [AW-1:0]   rs1,
    input  logic [AW-1:0]   rs2,
    output logic [XLEN-1:0] rv1,
    output logic [XLEN-1:0] rv2,
    input  logic [AW-1:0]   rd,
    input  logic            we,
    input  logic [XLEN-1:0] wdata,
    output logic            wr_dropped,
    input  logic            dump_start,
    output logic            dump_busy,
    output logic            dump_valid,
    input  logic            dump_ready,
    output logic [AW-1:0]   dump_idx,
    output logic [XLEN-1:0] dump_data,
    output logic            dump_done
);

    localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

    dump_state_t   state, next_state;
    logic [AW-1:0] next_idx;
    logic          busy_now;

    assign busy_now = (state != IDLE);

    regfile_core #(
        .XLEN     (XLEN),
        .NREGS    (NREGS),
        .ZERO_REG (ZERO_REG),
        .AW       (AW)
    ) u_core (
        .clk        (clk),
        .rst_n      (rst_n),
        .rs1        (rs1),
        .rs2        (rs2),
        .rs3        (dump_idx),
        .rv1        (rv1),
        .rv2        (rv2),
        .rv3        (dump_data),
        .rd         (rd),
        .we         (we),
        .wdata      (wdata),
        .wr_inhibit (busy_now)
    );

    // Next-state and index logic; the terminal beat always exits to DONE.
    always_comb begin
        next_state = state;
        next_idx   = dump_idx;
        case (state)
            IDLE: begin
                if (dump_start) begin
                    next_state = RUN;
                    next_idx   = '0;
                end
            end
            RUN: begin
                if (dump_ready) begin
                    if (dump_idx == LAST_IDX) begin
                        next_state = DONE;
                        next_idx   = '0;
                    end else begin
                        next_idx = dump_idx + 1'b1;
                    end
                end
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // State, index and all status outputs registered from next-state, so
    // nothing visible depends combinationally on dump_ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            dump_idx   <= '0;
            dump_valid <= 1'b0;
            dump_busy  <= 1'b0;
            dump_done  <= 1'b0;
            wr_dropped <= 1'b0;
        end else begin
            state      <= next_state;
            dump_idx   <= next_idx;
            dump_valid <= (next_state == RUN);
            dump_busy  <= (next_state != IDLE);
            dump_done  <= (next_state == DONE);
            wr_dropped <= we && busy_now && !((ZERO_REG != 0) && (rd == '0));
        end
    end

endmodule

// File: tb/tb_regfile_dump.sv
// Self-checking bench for regfile_dump: default 32x32 instance plus an
// 8x16 instance without a hardwired zero register.
module tb_regfile_dump;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    // Default instance
    logic [4:0]  rs1 = '0, rs2 = '0, rd = '0, dump_idx;
    logic [31:0] rv1, rv2, wdata = '0, dump_data;
    logic        we = 1'b0, dump_start = 1'b0, dump_ready = 1'b0;
    logic        wr_dropped, dump_busy, dump_valid, dump_done;

    // Small instance
    logic [2:0]  p_rs1 = '0, p_rs2 = '0, p_rd = '0, p_idx;
    logic [15:0] p_rv1, p_rv2, p_wdata = '0, p_data;
    logic        p_we = 1'b0, p_start = 1'b0, p_ready = 1'b0;
    logic        p_drop, p_busy, p_valid, p_done;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] mdl [32];
    logic [31:0] cap [32];

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;
    vec_t vt [6];

    always #5 clk = ~clk;

    regfile_dump dut (
        .clk(clk), .rst_n(rst_n), .rs1(rs1), .rs2(rs2), .rv1(rv1), .rv2(rv2),
        .rd(rd), .we(we), .wdata(wdata), .wr_dropped(wr_dropped),
        .dump_start(dump_start), .dump_busy(dump_busy), .dump_valid(dump_valid),
        .dump_ready(dump_ready), .dump_idx(dump_idx), .dump_data(dump_data),
        .dump_done(dump_done)
    );

    regfile_dump #(.XLEN(16), .NREGS(8), .ZERO_REG(0)) dut8 (
        .clk(clk), .rst_n(rst_n), .rs1(p_rs1), .rs2(p_rs2), .rv1(p_rv1), .rv2(p_rv2),
        .rd(p_rd), .we(p_we), .wdata(p_wdata), .wr_dropped(p_drop),
        .dump_start(p_start), .dump_busy(p_busy), .dump_valid(p_valid),
        .dump_ready(p_ready), .dump_idx(p_idx), .dump_data(p_data),
        .dump_done(p_done)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference rule: a write lands only when idle and not aimed at x0.
    task automatic mdl_write(input logic [4:0] r, input logic [31:0] d);
        if (r != 5'd0) mdl[r] = d;
    endtask

    // Run one full dump on the default instance and check every beat.
    // mode 0: ready held high; mode 1: ready pattern 1,0,0 repeating.
    task automatic run_dump(input string tag, input int mode,
                            input logic st_we, input logic [4:0] st_rd, input logic [31:0] st_wd,
                            input int wr_cyc, input logic [4:0] wr_rd, input int exp_drop);
        int acc, done_c, fall_c, drops, c;
        logic pv, pr;
        logic [4:0] pidx;
        logic [31:0] pdata;
        acc = 0; done_c = 0; fall_c = 0; drops = 0; pv = 0; pr = 0;
        pidx = '0; pdata = '0;
        dump_start = 1'b1; we = st_we; rd = st_rd; wdata = st_wd;
        tick();
        if (st_we) mdl_write(st_rd, st_wd);
        dump_start = 1'b0; we = 1'b0;
        c = 1;
        while (c < 400 && fall_c == 0) begin
            dump_ready = (mode == 0) ? 1'b1 : (((c - 1) % 3) == 0);
            we = (c == wr_cyc); rd = wr_rd; wdata = 32'hFF;
            drops += int'(wr_dropped);
            if (dump_done && done_c == 0) done_c = c;
            if (!dump_busy) fall_c = c;
            if (dump_valid) begin
                if (pv && !pr) begin
                    chk({tag, "_hold_idx"}, {27'd0, dump_idx}, {27'd0, pidx});
                    chk({tag, "_hold_data"}, dump_data, pdata);
                end
                if (acc < 32) begin
                    chk({tag, "_idx"}, {27'd0, dump_idx}, acc);
                    chk({tag, "_data"}, dump_data, mdl[acc]);
                    cap[acc] = dump_data;
                end else begin
                    chk({tag, "_overrun"}, acc, 32);
                end
                if (dump_ready) acc++;
            end
            pv = dump_valid; pr = dump_ready; pidx = dump_idx; pdata = dump_data;
            tick();
            c++;
        end
        we = 1'b0; dump_ready = 1'b0;
        chk({tag, "_beats"}, acc, 32);
        chk({tag, "_drops"}, drops, exp_drop);
        if (mode == 0) begin
            chk({tag, "_done_cyc"}, done_c, 33);
            chk({tag, "_idle_cyc"}, fall_c, 34);
        end else begin
            chk({tag, "_done_seen"}, {31'd0, done_c > 0}, 1);
            chk({tag, "_done_last"}, done_c, fall_c - 1);
        end
    endtask

    initial begin
        int c, beats, done_c;
        logic [15:0] b0, b5;
        logic seen;

        for (int i = 0; i < 32; i++) mdl[i] = '0;

        // Reset state
        tick();
        chk("rst_valid", {31'd0, dump_valid}, 0);
        chk("rst_busy", {31'd0, dump_busy}, 0);
        chk("rst_done", {31'd0, dump_done}, 0);
        chk("rst_drop", {31'd0, wr_dropped}, 0);
        chk("rst_idx", {27'd0, dump_idx}, 0);
        rs1 = 5'd5;
        #1;
        chk("rst_rv1", rv1, 0);
        rst_n = 1'b1;
        tick();

        // Basic write/read
        we = 1'b1; rd = 5'd5; wdata = 32'hDEADBEEF;
        tick();
        rd = 5'd0; wdata = 32'h1234;
        tick();
        we = 1'b0; rs1 = 5'd5; rs2 = 5'd0;
        #1;
        mdl[5] = 32'hDEADBEEF;
        chk("basic_rv1", rv1, 32'hDEADBEEF);
        chk("basic_rv2_x0", rv2, 0);
        chk("basic_drop", {31'd0, wr_dropped}, 0);

        // Read during same-cycle write sees the old value
        we = 1'b1; rd = 5'd5; wdata = 32'h0BAD_F00D; rs1 = 5'd5;
        #1;
        chk("rdw_old", rv1, 32'hDEADBEEF);
        tick();
        we = 1'b0;
        #1;
        chk("rdw_new", rv1, 32'h0BAD_F00D);
        mdl[5] = 32'h0BAD_F00D;

        // Table-driven write/readback
        vt[0] = '{rd: 5'd3,  wdata: 32'h0000_0001, exp: 32'h0000_0001};
        vt[1] = '{rd: 5'd31, wdata: 32'hFFFF_FFFF, exp: 32'hFFFF_FFFF};
        vt[2] = '{rd: 5'd0,  wdata: 32'hAAAA_5555, exp: 32'h0000_0000};
        vt[3] = '{rd: 5'd16, wdata: 32'h8000_0000, exp: 32'h8000_0000};
        vt[4] = '{rd: 5'd3,  wdata: 32'h1357_9BDF, exp: 32'h1357_9BDF};
        vt[5] = '{rd: 5'd1,  wdata: 32'h0000_0000, exp: 32'h0000_0000};
        for (int i = 0; i < 6; i++) begin
            we = 1'b1; rd = vt[i].rd; wdata = vt[i].wdata;
            tick();
            we = 1'b0; rs1 = vt[i].rd; rs2 = vt[i].rd;
            #1;
            chk("vec_rv1", rv1, vt[i].exp);
            chk("vec_rv2", rv2, vt[i].exp);
            mdl_write(vt[i].rd, vt[i].wdata);
        end

        // Randomized reads and writes against the model
        for (int i = 0; i < 150; i++) begin
            we = 1'($urandom_range(0, 1));
            rd = 5'($urandom); wdata = $urandom;
            rs1 = 5'($urandom); rs2 = 5'($urandom);
            #1;
            chk("rnd_rv1", rv1, mdl[rs1]);
            chk("rnd_rv2", rv2, mdl[rs2]);
            chk("rnd_drop", {31'd0, wr_dropped}, 0);
            tick();
            if (we) mdl_write(rd, wdata);
        end
        we = 1'b0;

        // Full dump with known contents
        for (int i = 1; i < 32; i++) begin
            we = 1'b1; rd = 5'(i); wdata = 32'(i * 3);
            tick();
            mdl_write(5'(i), 32'(i * 3));
        end
        we = 1'b0;
        tick();
        run_dump("full", 0, 1'b0, 5'd0, 32'd0, 0, 5'd0, 0);
        chk("full_b31", cap[31], 32'd93);
        chk("full_b0", cap[0], 32'd0);

        // Backpressure
        run_dump("bp", 1, 1'b0, 5'd0, 32'd0, 0, 5'd0, 0);

        // Write during dump is dropped; rd=0 drop is silent
        run_dump("wdrop", 0, 1'b0, 5'd0, 32'd0, 3, 5'd7, 1);
        rs1 = 5'd7;
        #1;
        chk("wdrop_x7", rv1, 32'd21);
        run_dump("wdrop0", 0, 1'b0, 5'd0, 32'd0, 3, 5'd0, 0);

        // Start with simultaneous write
        run_dump("stw0", 0, 1'b1, 5'd0, 32'h55, 0, 5'd0, 0);
        chk("stw0_b0", cap[0], 32'd0);
        run_dump("stw1", 0, 1'b1, 5'd1, 32'h55, 0, 5'd0, 0);
        chk("stw1_b1", cap[1], 32'h55);

        // Reset at beat 10 aborts the dump
        dump_start = 1'b1; dump_ready = 1'b1;
        tick();
        dump_start = 1'b0;
        c = 0;
        while (c < 50 && !(dump_valid && dump_idx == 5'd10)) begin
            tick();
            c++;
        end
        chk("mrst_reach10", {27'd0, dump_idx}, 10);
        rst_n = 1'b0;
        #1;
        chk("mrst_valid", {31'd0, dump_valid}, 0);
        chk("mrst_busy", {31'd0, dump_busy}, 0);
        chk("mrst_idx", {27'd0, dump_idx}, 0);
        chk("mrst_data", dump_data, 0);
        seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            seen = seen | dump_done;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            seen = seen | dump_done;
        end
        chk("mrst_no_done", {31'd0, seen}, 0);
        dump_ready = 1'b0; rs1 = 5'd1;
        #1;
        chk("mrst_x1", rv1, 0);
        for (int i = 0; i < 32; i++) mdl[i] = '0;

        // Small instance: x0 is an ordinary register
        p_we = 1'b1; p_rd = 3'd0; p_wdata = 16'hABCD;
        tick();
        p_rd = 3'd5; p_wdata = 16'h5A5A;
        tick();
        p_we = 1'b0; p_rs1 = 3'd0;
        #1;
        chk("p_rv1_x0", {16'd0, p_rv1}, 32'hABCD);
        p_start = 1'b1; p_ready = 1'b1;
        tick();
        p_start = 1'b0;
        beats = 0; done_c = 0; b0 = '0; b5 = '0;
        for (int i = 1; i < 40 && done_c == 0; i++) begin
            if (p_valid) begin
                chk("p_idx", {29'd0, p_idx}, beats);
                if (p_idx == 3'd0) b0 = p_data;
                if (p_idx == 3'd5) b5 = p_data;
                beats++;
            end
            if (p_done) done_c = i;
            tick();
        end
        chk("p_beats", beats, 8);
        chk("p_b0", {16'd0, b0}, 32'hABCD);
        chk("p_b5", {16'd0, b5}, 32'h5A5A);
        chk("p_done_cyc", done_c, 9);
        tick();
        chk("p_idle", {31'd0, p_busy}, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
